store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the CPU memory stage and data_mem.
- CPU stores are queued and retire to data_mem in the background, one at a time, using the data_mem two-cycle write handshake (memwrite, then clk_stall).
- Loads bypass the queue unless they hit a pending store's word, in which case the CPU is stalled until that store retires.

Parameters:
DEPTH, 4, number of queued stores; power of two, minimum 2.
PTR_W, 2, log2(DEPTH); occupancy counter is PTR_W+1 bits wide.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
cpu_addr  in  32  load/store byte address.
cpu_write_data  in  32  store data.
cpu_memwrite  in  1  store request, level, sampled each cycle.
cpu_memread  in  1  load request, level.
cpu_sign_mask  in  4  access size/sign code, same encoding as data_mem.
cpu_read_data  out  32  load data; combinational pass-through of mem_read_data.
cpu_stall  out  1  CPU must hold its request and stall the pipeline.
mem_addr  out  32  to data_mem addr.
mem_write_data  out  32  to data_mem write_data.
mem_memwrite  out  1  to data_mem memwrite.
mem_memread  out  1  to data_mem memread.
mem_sign_mask  out  4  to data_mem sign_mask.
mem_read_data  in  32  from data_mem read_data.
mem_clk_stall  in  1  from data_mem clk_stall.
sb_count  out  PTR_W+1  current occupancy.
sb_empty  out  1  sb_count == 0.

Behaviour:
- Storage: circular FIFO. Each entry holds {addr[31:0], data[31:0], sign_mask[3:0], valid}. Head and tail pointers wrap modulo DEPTH.
- Reset (async, rst_n=0):
  - Pointers, count and valid bits cleared; drain FSM to D_IDLE.
  - mem_memwrite=0, mem_memread=0, cpu_stall=0, sb_empty=1, sb_count=0.
  - A write already latched inside data_mem still completes there. Queued stores are discarded.
- Enqueue:
  - Condition: cpu_memwrite=1 && (count<DEPTH || pop this edge). Entry written at the posedge; cpu_stall=0 that cycle.
  - Full and no pop this cycle: cpu_stall=1, nothing written.
- Drain FSM:
  - D_IDLE: starts a drain when count>0 && no load is using the port this cycle. Latches the head entry and goes to D_ISSUE.
  - D_ISSUE (1 cycle): mem_memwrite=1; mem_addr, mem_write_data, mem_sign_mask driven from the head entry. Next state D_WAIT.
  - D_WAIT: mem_memwrite=0, mem_* still driven from the head entry. When mem_clk_stall=0, pop the head (valid cleared, head++) and return to D_IDLE.
  - Nominal occupancy is 3 cycles per store (IDLE decision, ISSUE, WAIT).
- Load path:
  - Hit: any valid entry with entry.addr[31:2]==cpu_addr[31:2]. Hit → cpu_stall=1 until no valid entry matches. No forwarding.
  - Miss, drain FSM in D_IDLE, and count<DEPTH: load owns the port. mem_memread=1, mem_addr=cpu_addr, mem_sign_mask=cpu_sign_mask, cpu_stall=0.
  - Miss but FSM in D_ISSUE/D_WAIT, or FIFO full: cpu_stall=1. When full, draining has priority over loads to prevent starvation.
- Port mux default, when neither a drain nor a load is active: mem_* driven from the head entry, with mem_memwrite=0 and mem_memread=0.
- Simultaneous cpu_memwrite and cpu_memread: illegal. The write is serviced and the read is ignored; the bench flags it as an assertion.
- Store to 0x2000 (LED) is queued like any other store; no special casing.
- Count arithmetic: +1 on enqueue, −1 on pop, unchanged when both occur on the same edge. Never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset: rst_n low mid-D_WAIT with count=3 → count=0, sb_empty=1, mem_memwrite=0, cpu_stall=0 immediately (async).
- Single store: sw 0x4000←0xDEADBEEF, cpu_memwrite for 1 cycle → no stall. Next cycle D_ISSUE with mem_memwrite=1, mem_addr=0x4000. Pop after mem_clk_stall falls; a later lw 0x4000 returns 0xDEADBEEF.
- Full: 5 back-to-back stores to 0x4000..0x4010 with DEPTH=4 → cpu_stall=1 on the 5th until the first pop. The 5th is accepted on the pop edge and count stays 4.
- RAW hazard: sb 0x4001←0xAA, then immediately lw 0x4000 → cpu_stall held until the store retires. Load then returns byte 0xAA at bits[15:8].
- Bypass: store queued to 0x4100, lw 0x4200 while the FSM is in D_IDLE → load issued the same cycle (mem_memread=1, mem_addr=0x4200) with no stall. Drain follows afterwards.
- Wrap-around: 10 stores with idle gaps → pointers wrap twice, all 10 words read back correctly, and sb_count returns to 0.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU memory stage and data_mem.
// Stores drain in the background one at a time; loads that hit a pending store word stall until it retires.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_write_data,
    input  logic             cpu_memwrite,
    input  logic             cpu_memread,
    input  logic [3:0]       cpu_sign_mask,
    output logic [31:0]      cpu_read_data,
    output logic             cpu_stall,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_memwrite,
    output logic             mem_memread,
    output logic [3:0]       mem_sign_mask,
    input  logic [31:0]      mem_read_data,
    input  logic             mem_clk_stall,
    output logic [PTR_W:0]   sb_count,
    output logic             sb_empty
);
    typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT} drain_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sign_mask;
    } entry_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    drain_state_t     state;

    logic full;
    logic hit;
    logic pop;
    logic push;
    logic load_active;
    logic start_drain;

    // NOTE: hit gets its default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr[31:2] == cpu_addr[31:2])) hit = 1'b1;
        end
    end

    assign full        = (count == FULL_COUNT);
    assign pop         = (state == D_WAIT) && !mem_clk_stall;
    assign push        = cpu_memwrite && (!full || pop);
    // A full buffer refuses loads so the drain cannot be starved.
    assign load_active = cpu_memread && !cpu_memwrite && !hit && (state == D_IDLE) && !full;
    assign start_drain = (state == D_IDLE) && (count != '0) && !load_active;

    assign cpu_stall      = cpu_memwrite ? !push : (cpu_memread && !load_active);
    assign cpu_read_data  = mem_read_data;
    assign mem_memread    = load_active;
    assign mem_addr       = load_active ? cpu_addr : entries[head].addr;
    assign mem_sign_mask  = load_active ? cpu_sign_mask : entries[head].sign_mask;
    assign mem_write_data = entries[head].data;
    assign sb_count       = count;
    assign sb_empty       = (count == '0);

    // NOTE: the entry storage has no reset; the valid bits alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            state        <= D_IDLE;
            mem_memwrite <= 1'b0;
        end else begin
            // NOTE: non-blocking updates; when push and pop hit the same slot the later push wins.
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                D_IDLE: begin
                    if (start_drain) begin
                        state        <= D_ISSUE;
                        mem_memwrite <= 1'b1;
                    end
                end
                D_ISSUE: begin
                    state        <= D_WAIT;
                    mem_memwrite <= 1'b0;
                end
                D_WAIT: begin
                    if (!mem_clk_stall) state <= D_IDLE;
                end
                default: begin
                    state        <= D_IDLE;
                    mem_memwrite <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a data_mem model with random write latency, a program-order
// golden memory and a queue of pending stores predict occupancy, stalls, retire order and load data.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int LIMIT = 60;
    localparam logic [3:0] SZ_B = 4'b0000;
    localparam logic [3:0] SZ_H = 4'b0001;
    localparam logic [3:0] SZ_W = 4'b0010;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    cpu_addr, cpu_write_data, cpu_read_data;
    logic           cpu_memwrite, cpu_memread, cpu_stall;
    logic [3:0]     cpu_sign_mask, mem_sign_mask;
    logic [31:0]    mem_addr, mem_write_data, mem_read_data;
    logic           mem_memwrite, mem_memread, mem_clk_stall;
    logic [PTR_W:0] sb_count;
    logic           sb_empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } st_t;

    st_t         q[$];
    logic [31:0] mem  [1024];
    logic [31:0] gold [1024];
    int          stall_cnt = 0;
    bit          pend_retire = 0;
    int          lat_min = 0;
    int          lat_max = 2;
    int          checks = 0;
    int          errors = 0;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
        .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall), .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        case (m[1:0])
            2'b00:   r[8*a[1:0] +: 8] = d[7:0];
            2'b01:   r[16*a[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // data_mem model: words land on the memwrite edge, clk_stall stays high for a random latency.
    assign mem_clk_stall = (stall_cnt != 0);
    assign mem_read_data = mem_memread ? mem[mem_addr[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            pend_retire = 1'b0;
        end else begin
            if (pend_retire && !mem_clk_stall) begin
                void'(q.pop_front());
                pend_retire = 1'b0;
            end
            if (cpu_memwrite && !cpu_stall) begin
                q.push_back('{cpu_addr, cpu_write_data, cpu_sign_mask});
                gold[cpu_addr[11:2]] = merge(gold[cpu_addr[11:2]], cpu_addr, cpu_write_data, cpu_sign_mask);
            end
        end
        if (mem_memwrite) begin
            check("issue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                check("issue_addr", mem_addr, q[0].addr);
                check("issue_data", mem_write_data, q[0].data);
                check("issue_mask", {28'h0, mem_sign_mask}, {28'h0, q[0].mask});
            end
            mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_addr, mem_write_data, mem_sign_mask);
            pend_retire = 1'b1;
            stall_cnt <= $urandom_range(lat_max, lat_min);
        end else if (stall_cnt != 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end

    always @(negedge clk) begin : monitor
        logic hit, full, retiring, busy, exp_stall;
        if (rst_n) begin
            full     = (q.size() == DEPTH);
            retiring = pend_retire && !mem_clk_stall;
            busy     = mem_memwrite || pend_retire;
            hit      = 1'b0;
            foreach (q[i]) if (q[i].addr[31:2] == cpu_addr[31:2]) hit = 1'b1;
            check("count", sb_count, q.size());
            check("empty", sb_empty, q.size() == 0);
            check("rw_exclusive", cpu_memwrite && cpu_memread, 0);
            if (cpu_memwrite) begin
                check("store_stall", cpu_stall, full && !retiring);
            end else if (cpu_memread) begin
                exp_stall = hit || busy || full;
                check("load_stall", cpu_stall, exp_stall);
                if (!exp_stall) begin
                    check("load_memread", mem_memread, 1);
                    check("load_addr", mem_addr, cpu_addr);
                    check("load_mask", {28'h0, mem_sign_mask}, {28'h0, cpu_sign_mask});
                    check("load_data", cpu_read_data, gold[cpu_addr[11:2]]);
                end
            end else begin
                check("no_load_memread", mem_memread, 0);
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            output int stalls);
        cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m; cpu_memwrite = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < LIMIT) begin
            stalls++;
            @(negedge clk);
        end
        check("store_timeout", stalls < LIMIT, 1);
        @(posedge clk);
        #1 cpu_memwrite = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] m,
                           output logic [31:0] rd, output int stalls);
        cpu_addr = a; cpu_sign_mask = m; cpu_memread = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < LIMIT) begin
            stalls++;
            @(negedge clk);
        end
        check("load_timeout", stalls < LIMIT, 1);
        rd = cpu_read_data;
        @(posedge clk);
        #1 cpu_memread = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!sb_empty && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, sb_empty, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, n, sz, off;
        int          sts[5];
        logic [31:0] a, rd;
        logic [3:0]  m;
        logic [31:0] wdata[10];

        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 32'h0;
            gold[i] = 32'h0;
        end
        cpu_addr = '0; cpu_write_data = '0; cpu_sign_mask = '0;
        cpu_memwrite = 1'b0; cpu_memread = 1'b0;

        #2;
        check("rst_count", sb_count, 0);
        check("rst_empty", sb_empty, 1);
        check("rst_memwrite", mem_memwrite, 0);
        check("rst_memread", mem_memread, 0);
        check("rst_stall", cpu_stall, 0);
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single store, then read it back.
        do_store(32'h4000, 32'hDEADBEEF, SZ_W, st);
        check("single_no_stall", st, 0);
        n = 0;
        @(negedge clk);
        while (!mem_memwrite && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("single_issue", mem_memwrite, 1);
        check("single_issue_addr", mem_addr, 32'h4000);
        check("single_issue_data", mem_write_data, 32'hDEADBEEF);
        wait_empty("single_drained");
        do_load(32'h4000, SZ_W, rd, st);
        check("single_readback", rd, 32'hDEADBEEF);

        // Five back-to-back stores into a four-entry buffer with a slow data_mem.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 5; i++) do_store(32'h4000 + 32'(4*i), 32'h11110000 + 32'(i), SZ_W, sts[i]);
        @(negedge clk);
        check("full_count_stays", sb_count, 4);
        check("full_first4_no_stall", sts[0] + sts[1] + sts[2] + sts[3], 0);
        check("full_fifth_stalled", sts[4] > 0, 1);
        @(posedge clk);
        #1;
        wait_empty("full_drained");
        lat_min = 0; lat_max = 2;

        // Byte store followed by a load of the same word.
        do_store(32'h4001, 32'h000000AA, SZ_B, st);
        do_load(32'h4000, SZ_W, rd, st);
        check("raw_stalled", st > 0, 1);
        check("raw_byte", {24'h0, rd[15:8]}, 32'hAA);
        check("raw_word", rd, 32'h1111AA00);

        // Load to an unrelated word bypasses a queued store.
        wait_empty("bypass_pre_empty");
        do_store(32'h4100, 32'hCAFE0001, SZ_W, st);
        cpu_addr = 32'h4200; cpu_sign_mask = SZ_W; cpu_memread = 1'b1;
        @(negedge clk);
        check("bypass_no_stall", cpu_stall, 0);
        check("bypass_memread", mem_memread, 1);
        check("bypass_addr", mem_addr, 32'h4200);
        check("bypass_count", sb_count, 1);
        @(posedge clk);
        #1 cpu_memread = 1'b0;
        wait_empty("bypass_drained");
        do_load(32'h4100, SZ_W, rd, st);
        check("bypass_store_landed", rd, 32'hCAFE0001);

        // Ten stores with gaps so the pointers wrap, then read everything back.
        for (int i = 0; i < 10; i++) begin
            wdata[i] = $urandom;
            do_store(32'h4300 + 32'(4*i), wdata[i], SZ_W, st);
            idle($urandom_range(3, 0));
        end
        wait_empty("wrap_drained");
        for (int i = 0; i < 10; i++) begin
            do_load(32'h4300 + 32'(4*i), SZ_W, rd, st);
            check("wrap_data", rd, wdata[i]);
        end
        check("wrap_count", sb_count, 0);

        // Random mix of stores, loads and idle cycles over a small address window.
        for (int i = 0; i < 300; i++) begin
            n   = $urandom_range(9, 0);
            a   = 32'h4000 + 32'($urandom_range(15, 0) << 2);
            off = $urandom_range(3, 0);
            if (n < 5) begin
                sz = $urandom_range(2, 0);
                m  = 4'(sz);
                if (sz == 0) a = a | 32'(off);
                else if (sz == 1) a = a | 32'(off & 2);
                do_store(a, $urandom, m, st);
            end else if (n < 9) begin
                do_load(a, SZ_W, rd, st);
            end else begin
                idle(1);
            end
        end
        wait_empty("rand_drained");

        // Asynchronous reset while the first of three stores is waiting on data_mem.
        lat_min = 2; lat_max = 2;
        do_store(32'h4380, 32'h0BAD0001, SZ_W, st);
        do_store(32'h4384, 32'h0BAD0002, SZ_W, st);
        do_store(32'h4388, 32'h0BAD0003, SZ_W, st);
        @(negedge clk);
        check("rst_pre_count", sb_count, 3);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_count", sb_count, 0);
        check("async_rst_empty", sb_empty, 1);
        check("async_rst_memwrite", mem_memwrite, 0);
        check("async_rst_stall", cpu_stall, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        lat_min = 0; lat_max = 2;
        idle(4);
        for (int i = 0; i < 1024; i++) gold[i] = mem[i];
        do_load(32'h4380, SZ_W, rd, st);
        check("rst_inflight_done", rd, 32'h0BAD0001);
        do_load(32'h4384, SZ_W, rd, st);
        check("rst_queued_discarded", rd, 32'h0);
        check("rst_final_count", sb_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
